// File: rtl/cla16_bist.sv
// cla16_bist: built-in self-test controller for a WIDTH-bit adder with an
// A/B/cin -> sum/cout interface. Drives LFSR-generated operand pairs, checks
// each result against an internal golden sum and reports pass/fail, a
// saturating error count and the first failing vector.
// Optional feature: define BIST_CORNER_EN to run four fixed corner vectors
// ahead of the random ones.
module cla16_bist #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [15:0] SEED_A      = 16'hACE1,
   parameter logic [15:0] SEED_B      = 16'h1D2B
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             cin_out,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             cout_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic             fail_cin
);

`ifdef BIST_CORNER_EN
   localparam int unsigned NUM_CORNER = 4;
`else
   localparam int unsigned NUM_CORNER = 0;
`endif
   localparam int unsigned TOTAL = NUM_VECTORS + NUM_CORNER;
   // 17 bits covers 65535 random vectors plus the corner vectors
   localparam int unsigned IDX_W = 17;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_t;

   state_t           state;
   state_t           state_next;
   logic [15:0]      lfsr_a;
   logic [15:0]      lfsr_b;
   logic [15:0]      lfsr_a_step;
   logic [15:0]      lfsr_b_step;
   logic [IDX_W-1:0] vec_idx;
   logic [IDX_W-1:0] idx_inc;
   logic [WIDTH-1:0] first_a;
   logic [WIDTH-1:0] first_b;
   logic             first_cin;
   logic [WIDTH-1:0] nxt_a;
   logic [WIDTH-1:0] nxt_b;
   logic             nxt_cin;
   logic             adv_lfsr;
   logic [WIDTH:0]   golden;
   logic             mismatch;

   // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left into bit 0
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

`ifdef BIST_CORNER_EN
   // Corner vectors packed as {a, b, cin}
   function automatic logic [2*WIDTH:0] corner_vec(input logic [1:0] k);
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] one;
      logic [WIDTH-1:0] msb;
      ones         = '1;
      one          = '0;
      one[0]       = 1'b1;
      msb          = '0;
      msb[WIDTH-1] = 1'b1;
      case (k)
         2'd0:    corner_vec = {{WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0};
         2'd1:    corner_vec = {ones, one, 1'b0};
         2'd2:    corner_vec = {ones, ones, 1'b1};
         default: corner_vec = {msb, msb, 1'b0};
      endcase
   endfunction
`endif

   assign lfsr_a_step = lfsr_next(lfsr_a);
   assign lfsr_b_step = lfsr_next(lfsr_b);
   assign golden      = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, cin_out};
   assign mismatch    = ({cout_in, sum_in} != golden);

   assign busy = (state == StDrive) || (state == StCheck);
   assign done = (state == StDone);
   assign pass = (state == StDone) && (err_count == 16'd0);

   // Select the first vector of a run and the vector following the current one
   always_comb begin
      idx_inc   = vec_idx + IDX_W'(1);
      adv_lfsr  = 1'b0;
      nxt_a     = WIDTH'(lfsr_a);
      nxt_b     = WIDTH'(lfsr_b);
      nxt_cin   = idx_inc[0];
      first_a   = WIDTH'(SEED_A);
      first_b   = WIDTH'(SEED_B);
      first_cin = 1'b0;
`ifdef BIST_CORNER_EN
      {first_a, first_b, first_cin} = corner_vec(2'd0);
      if (idx_inc < IDX_W'(NUM_CORNER)) begin
         {nxt_a, nxt_b, nxt_cin} = corner_vec(idx_inc[1:0]);
      end else if (vec_idx >= IDX_W'(NUM_CORNER)) begin
         // Leaving the last corner presents the unstepped seed; only
         // random-to-random transitions step the LFSRs.
         adv_lfsr = 1'b1;
         nxt_a    = WIDTH'(lfsr_a_step);
         nxt_b    = WIDTH'(lfsr_b_step);
      end
`else
      adv_lfsr = 1'b1;
      nxt_a    = WIDTH'(lfsr_a_step);
      nxt_b    = WIDTH'(lfsr_b_step);
`endif
   end

   // Next-state logic for the run sequencer
   always_comb begin
      state_next = state;
      case (state)
         StIdle, StDone: if (start) state_next = StDrive;
         StDrive:        state_next = StCheck;
         StCheck:        state_next = (vec_idx == LAST_IDX) ? StDone : StDrive;
         default:        state_next = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= StIdle;
      else     state <= state_next;
   end

   // Operand generation, result checking and failure capture
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_a    <= SEED_A;
         lfsr_b    <= SEED_B;
         vec_idx   <= '0;
         a_out     <= '0;
         b_out     <= '0;
         cin_out   <= 1'b0;
         err_count <= '0;
         fail_a    <= '0;
         fail_b    <= '0;
         fail_cin  <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  lfsr_a    <= SEED_A;
                  lfsr_b    <= SEED_B;
                  vec_idx   <= '0;
                  a_out     <= first_a;
                  b_out     <= first_b;
                  cin_out   <= first_cin;
                  err_count <= '0;
                  fail_a    <= '0;
                  fail_b    <= '0;
                  fail_cin  <= 1'b0;
               end
            end
            StCheck: begin
               if (mismatch) begin
                  if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                  if (err_count == 16'd0) begin
                     fail_a   <= a_out;
                     fail_b   <= b_out;
                     fail_cin <= cin_out;
                  end
               end
               // The final vector stays on the operand bus while DONE
               if (vec_idx != LAST_IDX) begin
                  vec_idx <= idx_inc;
                  a_out   <= nxt_a;
                  b_out   <= nxt_b;
                  cin_out <= nxt_cin;
                  if (adv_lfsr) begin
                     lfsr_a <= lfsr_a_step;
                     lfsr_b <= lfsr_b_step;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cla16_bist.sv
// tb_cla16_bist: randomized self-checking bench for cla16_bist. A behavioural
// adder (optionally faulty, optionally registered) closes the loop; expected
// vectors and error counts come from a plain-arithmetic reference model.
module tb_cla16_bist;

   localparam int NV = 8;
`ifdef BIST_CORNER_EN
   localparam int NCORNER = 4;
`else
   localparam int NCORNER = 0;
`endif
   localparam int T       = NV + NCORNER;
   localparam int MAX_CYC = 4 * T + 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a_out, b_out, sum_in;
   logic        cin_out, cout_in;
   logic        busy, done, pass;
   logic [15:0] err_count, fail_a, fail_b;
   logic        fail_cin;

   int          fault     = 0;    // 0 correct, 1 sum bit 3 stuck-at-0, 2 always wrong
   bit          reg_adder = 1'b0; // 1: adder output registered (1 cycle latency)
   logic [16:0] reg_res;
   logic [16:0] res;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_a[$], exp_b[$];
   logic        exp_c[$];
   logic [15:0] obs_a[$], obs_b[$], obs_sum[$], obs_err[$];
   logic        obs_c[$], obs_cout[$], obs_busy[$];

   cla16_bist #(
      .WIDTH      (16),
      .NUM_VECTORS(NV),
      .SEED_A     (16'hACE1),
      .SEED_B     (16'h1D2B)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_out    (a_out),
      .b_out    (b_out),
      .cin_out  (cin_out),
      .sum_in   (sum_in),
      .cout_in  (cout_in),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_count(err_count),
      .fail_a   (fail_a),
      .fail_b   (fail_b),
      .fail_cin (fail_cin)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] adder_model(input int f, input logic [15:0] a,
                                               input logic [15:0] b, input logic c);
      logic [16:0] r;
      r = {1'b0, a} + {1'b0, b} + {16'd0, c};
      if (f == 1)      r[3] = 1'b0;
      else if (f == 2) r    = r ^ 17'h10000;
      return r;
   endfunction

   always_ff @(posedge clk) reg_res <= adder_model(fault, a_out, b_out, cin_out);

   always_comb begin
      res = reg_adder ? reg_res : adder_model(fault, a_out, b_out, cin_out);
   end
   assign {cout_in, sum_in} = res;

   // Expected vector list straight from the seeds and the polynomial
   task automatic build_expected();
      logic [15:0] la, lb;
      exp_a.delete(); exp_b.delete(); exp_c.delete();
`ifdef BIST_CORNER_EN
      exp_a.push_back(16'h0000); exp_b.push_back(16'h0000); exp_c.push_back(1'b0);
      exp_a.push_back(16'hFFFF); exp_b.push_back(16'h0001); exp_c.push_back(1'b0);
      exp_a.push_back(16'hFFFF); exp_b.push_back(16'hFFFF); exp_c.push_back(1'b1);
      exp_a.push_back(16'h8000); exp_b.push_back(16'h8000); exp_c.push_back(1'b0);
`endif
      la = 16'hACE1;
      lb = 16'h1D2B;
      for (int i = 0; i < NV; i++) begin
         exp_a.push_back(la);
         exp_b.push_back(lb);
         exp_c.push_back(i[0]);
         la = (la << 1) | {15'd0, ^(la & 16'hB400)};
         lb = (lb << 1) | {15'd0, ^(lb & 16'hB400)};
      end
   endtask

   task automatic model_errors(input int f, output int n, output int first);
      n     = 0;
      first = -1;
      for (int k = 0; k < exp_a.size(); k++) begin
         int truth;
         truth = int'(exp_a[k]) + int'(exp_b[k]) + int'(exp_c[k]);
         if (int'(adder_model(f, exp_a[k], exp_b[k], exp_c[k])) != truth) begin
            n++;
            if (first < 0) first = k;
         end
      end
      if (n > 65535) n = 65535;
   endtask

   // Start a run (caller sits at a negedge) and record every busy cycle until done
   task automatic run_capture(input bit hold, output int cyc, output bit timed_out);
      obs_a.delete(); obs_b.delete(); obs_c.delete(); obs_sum.delete();
      obs_cout.delete(); obs_busy.delete(); obs_err.delete();
      cyc       = 0;
      timed_out = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         cyc++;
         if (done) break;
         obs_a.push_back(a_out);     obs_b.push_back(b_out);   obs_c.push_back(cin_out);
         obs_sum.push_back(sum_in);  obs_cout.push_back(cout_in);
         obs_busy.push_back(busy);   obs_err.push_back(err_count);
         if (cyc > MAX_CYC) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL reset_a: got %h expected 0000", a_out); end
      checks++; if (b_out !== 16'h0) begin errors++; $display("FAIL reset_b: got %h expected 0000", b_out); end
      checks++; if ({cin_out, busy, done, pass} !== 4'b0) begin errors++;
         $display("FAIL reset_flags: got %b expected 0000", {cin_out, busy, done, pass}); end
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got %h expected 0000", err_count); end
      checks++; if ({fail_a, fail_b, fail_cin} !== 33'h0) begin errors++;
         $display("FAIL reset_fail: got %h expected 0", {fail_a, fail_b, fail_cin}); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_basic();
      int cyc; bit to;
      fault = 0; reg_adder = 1'b0;
      build_expected();
      run_capture(1'b0, cyc, to);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
      checks++; if (cyc != 2 * T + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, 2 * T + 1); end
      if (obs_a.size() == 2 * T) begin
         for (int k = 0; k < T; k++) begin
            for (int p = 0; p < 2; p++) begin
               checks++;
               if ({obs_a[2*k+p], obs_b[2*k+p], obs_c[2*k+p], obs_busy[2*k+p]} !==
                   {exp_a[k], exp_b[k], exp_c[k], 1'b1}) begin
                  errors++;
                  $display("FAIL basic_vec%0d_%0d: got %h/%h/%b busy %b expected %h/%h/%b busy 1", k, p,
                           obs_a[2*k+p], obs_b[2*k+p], obs_c[2*k+p], obs_busy[2*k+p], exp_a[k], exp_b[k], exp_c[k]);
               end
            end
         end
         checks++;
         if ({obs_a[2*NCORNER], obs_b[2*NCORNER], obs_c[2*NCORNER]} !== {16'hACE1, 16'h1D2B, 1'b0}) begin
            errors++;
            $display("FAIL basic_first_random: got %h/%h/%b expected ace1/1d2b/0",
                     obs_a[2*NCORNER], obs_b[2*NCORNER], obs_c[2*NCORNER]);
         end
      end else begin
         checks++; errors++;
         $display("FAIL basic_capture_len: got %0d expected %0d", obs_a.size(), 2 * T);
      end
      checks++; if ({done, busy, pass} !== 3'b101) begin errors++; $display("FAIL basic_status: got %b expected 101", {done, busy, pass}); end
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL basic_err: got %h expected 0000", err_count); end
      repeat (3) @(negedge clk);
      checks++; if ({done, a_out, b_out} !== {1'b1, exp_a[T-1], exp_b[T-1]}) begin errors++;
         $display("FAIL basic_hold: got %b %h %h expected 1 %h %h", done, a_out, b_out, exp_a[T-1], exp_b[T-1]); end
   endtask

   task automatic test_stuck_bit3();
      int cyc, n, first; bit to;
      fault = 1; reg_adder = 1'b0;
      build_expected();
      model_errors(1, n, first);
      run_capture(1'b0, cyc, to);
      checks++; if (to || !done) begin errors++; $display("FAIL stuck_done: got %b expected 1", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b expected 0", pass); end
      checks++; if (err_count !== 16'(n)) begin errors++; $display("FAIL stuck_err: got %0d expected %0d", err_count, n); end
      if (first >= 0) begin
         checks++;
         if ({fail_a, fail_b, fail_cin} !== {exp_a[first], exp_b[first], exp_c[first]}) begin
            errors++;
            $display("FAIL stuck_first: got %h/%h/%b expected %h/%h/%b", fail_a, fail_b, fail_cin,
                     exp_a[first], exp_b[first], exp_c[first]);
         end
      end
   endtask

   task automatic test_start_ignored_and_reset();
      int cyc, vi; bit to;
      fault = 0; reg_adder = 1'b0;
      build_expected();
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start = (c == 2);  // stray start while busy
         vi = (c - 1) / 2;
         checks++;
         if ({a_out, b_out, cin_out, busy} !== {exp_a[vi], exp_b[vi], exp_c[vi], 1'b1}) begin
            errors++;
            $display("FAIL busy_start_c%0d: got %h/%h/%b busy %b expected %h/%h/%b busy 1", c,
                     a_out, b_out, cin_out, busy, exp_a[vi], exp_b[vi], exp_c[vi]);
         end
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({a_out, b_out, cin_out, busy, done, pass} !== 36'h0) begin errors++;
         $display("FAIL midrun_reset_out: got %h/%h/%b %b%b%b expected all 0", a_out, b_out, cin_out, busy, done, pass); end
      checks++; if ({err_count, fail_a, fail_b, fail_cin} !== 49'h0) begin errors++;
         $display("FAIL midrun_reset_res: got %h %h %h %b expected all 0", err_count, fail_a, fail_b, fail_cin); end
      repeat (2) @(negedge clk);
      checks++; if ({busy, a_out} !== 17'h0) begin errors++; $display("FAIL midrun_reset_idle: got %b %h expected 0 0000", busy, a_out); end
      run_capture(1'b0, cyc, to);
      checks++; if (cyc != 2 * T + 1) begin errors++; $display("FAIL replay_latency: got %0d expected %0d", cyc, 2 * T + 1); end
      if (obs_a.size() == 2 * T) begin
         for (int k = 0; k < T; k++) begin
            checks++;
            if ({obs_a[2*k], obs_b[2*k], obs_c[2*k]} !== {exp_a[k], exp_b[k], exp_c[k]}) begin
               errors++;
               $display("FAIL replay_vec%0d: got %h/%h/%b expected %h/%h/%b", k,
                        obs_a[2*k], obs_b[2*k], obs_c[2*k], exp_a[k], exp_b[k], exp_c[k]);
            end
         end
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL replay_pass: got %b expected 1", pass); end
   endtask

   task automatic test_saturation();
      int cyc; bit got_done, wrapped; logic [15:0] prev;
      fault = 2; reg_adder = 1'b0;
      build_expected();
      cyc = 0; got_done = 1'b0; wrapped = 1'b0; prev = 16'h0;
      start = 1'b1;
      @(posedge clk);
      while (cyc < MAX_CYC) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (cyc == 3) begin
            checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL sat_first_err: got %h expected 0001", err_count); end
            force dut.err_count = 16'hFFFD;  // preset close to the ceiling
            #1;
            release dut.err_count;
            prev = 16'hFFFD;
         end else if (cyc > 3) begin
            if (err_count < prev) wrapped = 1'b1;
            prev = err_count;
         end
         if (done) begin
            got_done = 1'b1;
            break;
         end
      end
      checks++; if (!got_done) begin errors++; $display("FAIL sat_timeout: got no done expected done"); end
      checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h expected ffff", err_count); end
      checks++; if (wrapped) begin errors++; $display("FAIL sat_wrap: got wrap expected monotonic"); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", pass); end
      checks++; if ({fail_a, fail_b, fail_cin} !== {exp_a[0], exp_b[0], exp_c[0]}) begin errors++;
         $display("FAIL sat_first: got %h/%h/%b expected %h/%h/%b", fail_a, fail_b, fail_cin, exp_a[0], exp_b[0], exp_c[0]); end
   endtask

`ifdef BIST_CORNER_EN
   task automatic test_corner();
      int cyc; bit to;
      fault = 0; reg_adder = 1'b0;
      build_expected();
      run_capture(1'b0, cyc, to);
      checks++; if (cyc != 2 * T + 1) begin errors++; $display("FAIL corner_latency: got %0d expected %0d", cyc, 2 * T + 1); end
      if (obs_a.size() == 2 * T) begin
         checks++; if ({obs_a[2], obs_b[2]} !== {16'hFFFF, 16'h0001}) begin errors++;
            $display("FAIL corner_v1_ops: got %h/%h expected ffff/0001", obs_a[2], obs_b[2]); end
         checks++; if ({obs_cout[3], obs_sum[3]} !== 17'h10000) begin errors++;
            $display("FAIL corner_v1_sum: got %b/%h expected 1/0000", obs_cout[3], obs_sum[3]); end
         checks++; if ({obs_cout[5], obs_sum[5]} !== 17'h1FFFF) begin errors++;
            $display("FAIL corner_v2_sum: got %b/%h expected 1/ffff", obs_cout[5], obs_sum[5]); end
         checks++; if ({obs_a[6], obs_b[6], obs_c[6]} !== {16'h8000, 16'h8000, 1'b0}) begin errors++;
            $display("FAIL corner_v3_ops: got %h/%h/%b expected 8000/8000/0", obs_a[6], obs_b[6], obs_c[6]); end
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL corner_pass: got %b expected 1", pass); end
   endtask
`endif

   task automatic test_back_to_back();
      int cyc1, cyc2, n, first; bit to1, to2;
      logic [15:0] err1; logic [32:0] fail1;
      fault = 1; reg_adder = 1'b1;
      build_expected();
      model_errors(1, n, first);
      run_capture(1'b1, cyc1, to1);
      err1  = err_count;
      fail1 = {fail_a, fail_b, fail_cin};
      checks++; if (cyc1 != 2 * T + 1) begin errors++; $display("FAIL b2b_run1_latency: got %0d expected %0d", cyc1, 2 * T + 1); end
      checks++; if (err1 !== 16'(n)) begin errors++; $display("FAIL b2b_run1_err: got %0d expected %0d", err1, n); end
      run_capture(1'b1, cyc2, to2);  // start still high in DONE
      start = 1'b0;
      checks++; if (cyc2 != 2 * T + 1) begin errors++; $display("FAIL b2b_run2_latency: got %0d expected %0d", cyc2, 2 * T + 1); end
      if (obs_err.size() > 0) begin
         checks++; if ({obs_busy[0], obs_err[0]} !== {1'b1, 16'h0}) begin errors++;
            $display("FAIL b2b_restart: got busy %b err %h expected busy 1 err 0000", obs_busy[0], obs_err[0]); end
         checks++; if ({obs_a[0], obs_b[0]} !== {exp_a[0], exp_b[0]}) begin errors++;
            $display("FAIL b2b_reseed: got %h/%h expected %h/%h", obs_a[0], obs_b[0], exp_a[0], exp_b[0]); end
      end
      checks++; if ({err_count, fail_a, fail_b, fail_cin} !== {err1, fail1}) begin errors++;
         $display("FAIL b2b_identical: got %h %h expected %h %h", err_count, {fail_a, fail_b, fail_cin}, err1, fail1); end
      if (first >= 0) begin
         checks++;
         if ({fail_a, fail_b, fail_cin} !== {exp_a[first], exp_b[first], exp_c[first]}) begin
            errors++;
            $display("FAIL b2b_first: got %h/%h/%b expected %h/%h/%b", fail_a, fail_b, fail_cin,
                     exp_a[first], exp_b[first], exp_c[first]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      test_reset();
      test_basic();
      test_stuck_bit3();
      test_start_ignored_and_reset();
      test_saturation();
`ifdef BIST_CORNER_EN
      test_corner();
`endif
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla16_bist.md
# cla16_bist

Built-in self-test controller for the 16-bit carry-lookahead adder. It drives pseudo-random operand pairs and carry-in into an external adder, then samples the adder's sum and carry-out. Each result is compared against an internally computed golden value, and the block reports pass/fail, an error count and the first failing vector. It sits beside the adder on the datapath test harness and replaces hand-written stimulus for regression of any adder with the same A/B/cin → sum/cout interface.

## Interface
- WIDTH, 16, operand/sum width
- NUM_VECTORS, 256, random vectors per run (1..65535)
- SEED_A, 16'hACE1, LFSR seed for A (nonzero)
- SEED_B, 16'h1D2B, LFSR seed for B (nonzero)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled only in IDLE/DONE
- a_out  out  WIDTH  operand A to adder
- b_out  out  WIDTH  operand B to adder
- cin_out  out  1  carry-in to adder
- sum_in  in  WIDTH  adder sum
- cout_in  in  1  adder carry-out
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid while done: err_count == 0
- err_count  out  16  mismatches this run, saturating at 16'hFFFF
- fail_a, fail_b  out  WIDTH  operands of first mismatch
- fail_cin  out  1  carry-in of first mismatch

## Operation
- FSM states: IDLE → DRIVE → CHECK → (DRIVE | DONE); DONE → DRIVE on start.
- IDLE/DONE + start=1: load LFSRs with seeds, clear err_count, fail_*, vec index; go DRIVE.
- DRIVE: a_out/b_out/cin_out present current vector; go CHECK.
- CHECK: operands held; at clock edge compare {cout_in,sum_in} with golden {1'b0,a_out}+{1'b0,b_out}+cin_out (WIDTH+1 bits). Mismatch: err_count+1 (saturate); if first mismatch, capture fail_a/fail_b/fail_cin.
- After CHECK: advance both LFSRs one step; vec index+1; if index == total−1 go DONE, else DRIVE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
- cin_out = vec index bit 0 (alternating 0,1 starting at 0).
- DONE: done=1, busy=0, pass = (err_count==0); outputs and operands held.
- start while busy: ignored.
- rst at any time, including mid-run: state IDLE, all outputs 0, LFSRs reloaded with seeds; no partial result is retained.

## Timing
- Reset values: a_out=0, b_out=0, cin_out=0, busy=0, done=0, pass=0, err_count=0, fail_*=0.
- start sampled at edge t0 → busy=1 and first vector on a_out from t0+1.
- Operands stable 2 cycles per vector; adder may be combinational or have 1 cycle registered latency.
- Sample point: edge ending CHECK.
- done=1 from t0+1+2·total; busy falls at the same edge.
- done=1 and start=1 at the same edge: new run begins and done drops next cycle.

## Configuration
- BIST_CORNER_EN defined: 4 corner vectors precede the random ones, total = NUM_VECTORS+4:
  - 0000+0000 cin0
  - FFFF+0001 cin0
  - FFFF+FFFF cin1
  - 8000+8000 cin0
- LFSR stepping starts only after the corner vectors; cin for random vectors uses the random-vector index.
- Not defined: random vectors only, total = NUM_VECTORS.

## Test plan
- Behavioural correct adder, NUM_VECTORS=8, start pulse → done at t0+17, pass=1, err_count=0, first vector a_out=ACE1, b_out=1D2B, cin_out=0.
- Adder model with sum bit 3 stuck-at-0 → done, pass=0, err_count>0, fail_a/fail_b/fail_cin equal the first vector whose true sum bit 3 is 1.
- start asserted during busy, then rst asserted mid-run at vector 3 → start has no effect; after rst all outputs 0 and state IDLE; a new start replays the identical vector sequence from seeds.
- Adder model always wrong, NUM_VECTORS=65535 with a forced counter preset in bench → err_count saturates at FFFF and does not wrap.
- BIST_CORNER_EN defined, correct adder → vector 1 a_out=FFFF, b_out=0001, sampled sum=0000, cout=1. Vector 2: sum=FFFF, cout=1. Run total 2·(NUM_VECTORS+4) cycles, pass=1.
- Back-to-back runs, start held high in DONE → second run restarts from seeds, err_count cleared, identical results.
